jtag_master_engine: RTL and testbench

System-side JTAG initiator that drives TCK/TMS/TDI toward a chain containing roalogic_jtag_tap and samples TDO.
- Accepts one command at a time over a valid/ready interface: RESET, SHIFT_IR, SHIFT_DR or IDLE.
- Generates the TMS walk, divides clk into TCK, and returns captured TDO bits.
- Tracks the target TAP state internally; rests in RunTestIdle between commands.

---
 rtl/jtag_master_engine_if.sv | 32 +++
 rtl/jtag_master_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_jtag_master_engine.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_master_engine_if.sv
// Command/response bundle for jtag_master_engine.
//   cmd_valid/cmd_ready : one-command-at-a-time handshake
//   cmd_op              : 0=RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=IDLE
//   cmd_len             : shift bit count or IDLE TCK count (0 or >MAX_LEN -> MAX_LEN)
//   cmd_data            : TDI bits, LSB shifted first
//   rsp_valid           : one-clk completion pulse
//   rsp_data            : captured TDO, held until the next completion
//   busy                : command in progress
// master = command issuer, slave = engine.
interface jtag_master_engine_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_master_engine.sv
// jtag_master_engine: system-side JTAG initiator.
// Accepts RESET / SHIFT_IR / SHIFT_DR / IDLE commands, generates the TMS walk,
// divides clk into TCK (CLK_DIV clk low, then CLK_DIV clk high per bit),
// drives TDI, samples TDO and returns the captured bits. The target TAP is
// assumed to rest in RunTestIdle between commands; until a reset sequence has
// been issued (synced=0) every SHIFT/IDLE is preceded by one.
// Ports:
//   clk, tap_resetn (async, active-low)
//   bus        : jtag_master_engine_if.slave (cmd_*, rsp_*, busy)
//   jtag_tck/jtag_tms/jtag_tdi out, jtag_tdo in
//   jtag_trstn out, only when JTAG_MASTER_TRST_EN is defined: pulsed low for
//   2*CLK_DIV clk at the start of every reset sequence.
// Optional feature macro: JTAG_MASTER_TRST_EN (undefined by default).
module jtag_master_engine #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  tap_resetn,
  jtag_master_engine_if.slave   bus,
  output logic                  jtag_tck,
  output logic                  jtag_tms,
  output logic                  jtag_tdi,
`ifdef JTAG_MASTER_TRST_EN
  output logic                  jtag_trstn,
`endif
  input  logic                  jtag_tdo
);

  localparam int CNT_W = $clog2(2 * CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] LAST_LOW  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_HIGH = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);

  localparam logic [1:0] OP_RESET    = 2'd0;
  localparam logic [1:0] OP_SHIFT_IR = 2'd1;
  localparam logic [1:0] OP_SHIFT_DR = 2'd2;
  localparam logic [1:0] OP_IDLE     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_RST, S_WALK_IN, S_SHIFT, S_WALK_OUT, S_RTI_WAIT, S_DONE
  } state_t;

  state_t             state;
  state_t             nxt_state;
  logic [LEN_W-1:0]   idx;        // bit index within the current state
  logic [LEN_W-1:0]   nxt_idx;
  logic [CNT_W-1:0]   cnt;        // clk count within the current TCK bit
  logic [1:0]         op_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   len_last;
  logic [LEN_W-1:0]   norm_len;
  logic [MAX_LEN-1:0] data_r;
  logic [MAX_LEN-1:0] data_sh;
  logic [MAX_LEN-1:0] cap;
  logic               synced;
  logic               rst_done;
  logic               accept;
  logic               nxt_tms;
  logic               nxt_tdi;
`ifdef JTAG_MASTER_TRST_EN
  logic               trst_ph;    // TRST low window ahead of the TMS reset walk
`endif

  // TMS value for bit i of a given sequence state; all sequences start in RTI.
  function automatic logic tms_of(state_t st, logic [LEN_W-1:0] i,
                                  logic [1:0] op, logic [LEN_W-1:0] last);
    case (st)
      S_PRE_RST:  tms_of = (i < LEN_W'(5));                     // 1,1,1,1,1,0
      S_WALK_IN:  tms_of = (op == OP_SHIFT_IR) ? (i < LEN_W'(2)) // 1,1,0,0
                                                : (i == '0);     // 1,0,0
      S_SHIFT:    tms_of = (i == last);                          // exit on last bit
      S_WALK_OUT: tms_of = (i == '0);                            // 1,0
      default:    tms_of = 1'b0;
    endcase
  endfunction

  assign accept   = (state == S_IDLE) && bus.cmd_valid && bus.cmd_ready;
  assign norm_len = ((bus.cmd_len == '0) || (bus.cmd_len > LEN_MAX)) ? LEN_MAX : bus.cmd_len;
  assign len_last = len_r - LEN_W'(1);

  // Which bit follows the current one once its falling TCK edge is reached.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx + LEN_W'(1);
    rst_done  = 1'b0;
    case (state)
      S_PRE_RST: begin
        if (idx == LEN_W'(5)) begin
          rst_done = 1'b1;
          nxt_idx  = '0;
          case (op_r)
            OP_RESET: nxt_state = S_DONE;
            OP_IDLE:  nxt_state = S_RTI_WAIT;
            default:  nxt_state = S_WALK_IN;
          endcase
        end
      end
      S_WALK_IN: begin
        if (idx == ((op_r == OP_SHIFT_IR) ? LEN_W'(3) : LEN_W'(2))) begin
          nxt_state = S_SHIFT;
          nxt_idx   = '0;
        end
      end
      S_SHIFT: begin
        if (idx == len_last) begin
          nxt_state = S_WALK_OUT;
          nxt_idx   = '0;
        end
      end
      S_WALK_OUT: begin
        if (idx == LEN_W'(1)) nxt_state = S_DONE;
      end
      S_RTI_WAIT: begin
        if (idx == len_last) nxt_state = S_DONE;
      end
      default: ;
    endcase
  end

  assign data_sh = data_r >> nxt_idx;
  assign nxt_tms = tms_of(nxt_state, nxt_idx, op_r, len_last);
  assign nxt_tdi = (nxt_state == S_SHIFT) && data_sh[0];

  always_ff @(posedge clk or negedge tap_resetn) begin
    if (!tap_resetn) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      op_r          <= OP_RESET;
      len_r         <= LEN_MAX;
      synced        <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      jtag_tck      <= 1'b0;
      jtag_tms      <= 1'b1;
      jtag_tdi      <= 1'b0;
`ifdef JTAG_MASTER_TRST_EN
      trst_ph       <= 1'b0;
      jtag_trstn    <= 1'b0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
`ifdef JTAG_MASTER_TRST_EN
      jtag_trstn    <= ~trst_ph;
`endif
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_r          <= bus.cmd_op;
            len_r         <= norm_len;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            cnt           <= '0;
            idx           <= '0;
            jtag_tdi      <= 1'b0;
            if ((bus.cmd_op == OP_RESET) || !synced) begin
              state    <= S_PRE_RST;
              jtag_tms <= 1'b1;
`ifdef JTAG_MASTER_TRST_EN
              trst_ph    <= 1'b1;
              jtag_trstn <= 1'b0;
`endif
            end else if (bus.cmd_op == OP_IDLE) begin
              state    <= S_RTI_WAIT;
              jtag_tms <= 1'b0;
            end else begin
              state    <= S_WALK_IN;
              jtag_tms <= 1'b1;
            end
          end
        end
        S_DONE: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= cap;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
        default: begin
`ifdef JTAG_MASTER_TRST_EN
          if (trst_ph) begin
            if (cnt == LAST_HIGH) begin
              trst_ph    <= 1'b0;
              jtag_trstn <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else
`endif
          if (cnt == LAST_LOW) begin
            jtag_tck <= 1'b1;
            cnt      <= cnt + CNT_W'(1);
          end else if (cnt == LAST_HIGH) begin
            // Falling edge: launch the next bit's TMS/TDI, or finish with TMS=0.
            jtag_tck <= 1'b0;
            cnt      <= '0;
            state    <= nxt_state;
            idx      <= nxt_idx;
            if (rst_done) synced <= 1'b1;
            if (nxt_state != S_DONE) begin
              jtag_tms <= nxt_tms;
              jtag_tdi <= nxt_tdi;
            end else begin
              jtag_tdi <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // TDO is taken on the clk where TCK rises; capture clears per command.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_r <= bus.cmd_data;
      cap    <= '0;
    end else if ((state == S_SHIFT) && (cnt == LAST_LOW)) begin
      cap <= cap | (MAX_LEN'(jtag_tdo) << idx);
    end
  end

endmodule

// File: tb/tb_jtag_master_engine.sv
module tb_jtag_master_engine;
  localparam int CLK_DIV = 4;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam logic [3:0]  IR_IDCODE  = 4'b0010;
  localparam logic [31:0] IDCODE_VAL = 32'h0000_09DD;

  logic clk = 1'b0;
  logic tap_resetn = 1'b0;
  logic jtag_tck, jtag_tms, jtag_tdi;
  logic jtag_tdo = 1'b0;
`ifdef JTAG_MASTER_TRST_EN
  logic jtag_trstn;
`endif

  int errors = 0;
  int checks = 0;

  jtag_master_engine_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus();

  jtag_master_engine #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .tap_resetn(tap_resetn), .bus(bus),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
`ifdef JTAG_MASTER_TRST_EN
    .jtag_trstn(jtag_trstn),
`endif
    .jtag_tdo(jtag_tdo)
  );

  always #5 clk = ~clk;

  // ---------------- target TAP model (IR=4 bits, IDCODE + BYPASS) ----------
  int          tap_st = 0;   // 0=TLR 1=RTI 2=SelDR 3=CapDR 4=ShDR 5=Ex1DR 6=PauDR 7=Ex2DR 8=UpdDR
  logic [3:0]  tap_ir = IR_IDCODE; // 9=SelIR 10=CapIR 11=ShIR 12=Ex1IR 13=PauIR 14=Ex2IR 15=UpdIR
  logic [3:0]  tap_irsh = 4'b0;
  logic [31:0] tap_dr = 32'b0;
  logic        tap_bp = 1'b0;

  function automatic int tap_next(input int s, input logic t);
    case (s)
      0: return t ? 0 : 1;    1: return t ? 2 : 1;
      2: return t ? 9 : 3;    3: return t ? 5 : 4;
      4: return t ? 5 : 4;    5: return t ? 8 : 6;
      6: return t ? 7 : 6;    7: return t ? 8 : 4;
      8: return t ? 2 : 1;    9: return t ? 0 : 10;
      10: return t ? 12 : 11; 11: return t ? 12 : 11;
      12: return t ? 15 : 13; 13: return t ? 14 : 13;
      14: return t ? 15 : 11; default: return t ? 2 : 1;
    endcase
  endfunction

  always @(posedge jtag_tck) begin
    case (tap_st)
      3:  begin tap_dr = IDCODE_VAL; tap_bp = 1'b0; end
      4:  begin tap_dr = {jtag_tdi, tap_dr[31:1]}; tap_bp = jtag_tdi; end
      10: tap_irsh = 4'b0001;
      11: tap_irsh = {jtag_tdi, tap_irsh[3:1]};
      15: tap_ir = tap_irsh;
      default: ;
    endcase
    tap_st = tap_next(tap_st, jtag_tms);
    if (tap_st == 0) tap_ir = IR_IDCODE;
  end

  always @(negedge jtag_tck) begin
    if (tap_st == 4)       jtag_tdo = (tap_ir == IR_IDCODE) ? tap_dr[0] : tap_bp;
    else if (tap_st == 11) jtag_tdo = tap_irsh[0];
    else                   jtag_tdo = 1'b0;
  end

  // ---------------- pin monitor: TMS per rising TCK, phase lengths ---------
  logic [127:0] mon_seq = '0;
  int  mon_ntck = 0;
  int  phase_bad = 0;
  bit  mon_en = 1'b0;
  int  run = 0;
  logic prev_tck = 1'b0, prev_tms = 1'b1, prev_tdi = 1'b0;

  always @(negedge clk) begin
    if (jtag_tck === prev_tck) run++;
    else begin
      if (mon_en && prev_tck && run != CLK_DIV) phase_bad++;
      if (mon_en && !prev_tck && mon_ntck > 0 && run != CLK_DIV) phase_bad++;
      if (jtag_tck) begin
        if (mon_ntck < 128) mon_seq[mon_ntck] = jtag_tms;
        mon_ntck++;
      end
      run = 1;
    end
    if (mon_en && prev_tck && jtag_tck && (jtag_tms !== prev_tms || jtag_tdi !== prev_tdi))
      phase_bad++;
    prev_tck = jtag_tck; prev_tms = jtag_tms; prev_tdi = jtag_tdi;
  end

  // ---------------- reference model of the engine ---------------------------
  bit         m_synced = 1'b0;
  logic [3:0] m_ir = IR_IDCODE;

  function automatic int norm_len(input int len);
    return (len == 0 || len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  function automatic void exp_seq(input int op, input int n, input bit sync,
                                  output logic [127:0] seq, output int cnt);
    seq = '0; cnt = 0;
    if (op == 0 || !sync) for (int k = 0; k < 6; k++) begin seq[cnt] = (k < 5); cnt++; end
    if (op == 1) begin seq[cnt] = 1'b1; seq[cnt+1] = 1'b1; cnt += 4; end
    else if (op == 2) begin seq[cnt] = 1'b1; cnt += 3; end
    if (op == 1 || op == 2) begin cnt += n; seq[cnt-1] = 1'b1; seq[cnt] = 1'b1; cnt += 2; end
    if (op == 3) cnt += n;
  endfunction

  // Expected response and TMS walk; advances the model's TAP knowledge.
  task automatic model_step(input int op, input int len, input logic [31:0] data,
                            output logic [31:0] exp_rsp, output logic [127:0] seq, output int cnt);
    int n; logic [31:0] mask; logic [63:0] full;
    n = norm_len(len);
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    exp_seq(op, n, m_synced, seq, cnt);
    if (op == 0 || !m_synced) begin m_ir = IR_IDCODE; m_synced = 1'b1; end
    exp_rsp = '0;
    if (op == 1) begin
      full = ({32'b0, data & mask} << 4) | 64'h1;
      exp_rsp = full[31:0] & mask;
      full = full >> n;
      m_ir = full[3:0];
    end else if (op == 2) begin
      exp_rsp = (m_ir == IR_IDCODE) ? (IDCODE_VAL & mask) : ((data << 1) & mask);
    end
  endtask

  // ---------------- command driver ------------------------------------------
  task automatic do_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                        input bit hold, output logic [31:0] rsp, output bit ready_ok,
                        output int pulses, output bit end_ok, output bit tmo);
    int waited;
    mon_seq = '0; mon_ntck = 0; phase_bad = 0; mon_en = 1'b1;
    ready_ok = 1'b1; pulses = 0; end_ok = 1'b0; tmo = 1'b0; rsp = '0;
    waited = 0;
    while (!bus.cmd_ready && waited < 100) begin @(posedge clk); #1; waited++; end
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_len = LEN_W'(len); bus.cmd_data = data;
    @(posedge clk); #1;
    if (hold) begin bus.cmd_op = 2'd0; bus.cmd_data = ~data; end
    else bus.cmd_valid = 1'b0;
    waited = 0;
    while (!bus.rsp_valid && waited < 3000) begin
      if (bus.cmd_ready) ready_ok = 1'b0;
      @(posedge clk); #1; waited++;
    end
    bus.cmd_valid = 1'b0;
    if (!bus.rsp_valid) tmo = 1'b1;
    else begin pulses = 1; rsp = bus.rsp_data; end
    @(posedge clk); #1;
    if (bus.rsp_valid) pulses++;
    end_ok = !jtag_tck && !jtag_tms && bus.cmd_ready && !bus.busy && !tmo;
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    tap_resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.cmd_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got=%h want=0", bus.rsp_data); end
    checks++; if (jtag_tck !== 1'b0) begin errors++; $display("FAIL reset_tck got=%b want=0", jtag_tck); end
    checks++; if (jtag_tms !== 1'b1) begin errors++; $display("FAIL reset_tms got=%b want=1", jtag_tms); end
    checks++; if (jtag_tdi !== 1'b0) begin errors++; $display("FAIL reset_tdi got=%b want=0", jtag_tdi); end
    tap_resetn = 1'b1;
    m_synced = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_cmd();
    logic [31:0] rsp, er; logic [127:0] es; int ec, p; bit rok, eok, tmo;
    model_step(0, 0, 32'h0, er, es, ec);
    do_cmd(2'd0, 0, 32'hFFFF_FFFF, 1'b0, rsp, rok, p, eok, tmo);
    checks++; if (mon_ntck !== 6) begin errors++; $display("FAIL rst_tck_count got=%0d want=6", mon_ntck); end
    checks++; if (mon_seq[5:0] !== 6'b011111 || mon_ntck != ec) begin errors++; $display("FAIL rst_tms_seq got=%b want=011111", mon_seq[5:0]); end
    checks++; if (rsp !== 32'h0) begin errors++; $display("FAIL rst_rsp got=%h want=0", rsp); end
    checks++; if (!rok) begin errors++; $display("FAIL rst_ready_low got=ready_seen want=low"); end
    checks++; if (p !== 1) begin errors++; $display("FAIL rst_pulse got=%0d want=1", p); end
    checks++; if (phase_bad !== 0) begin errors++; $display("FAIL rst_tck_phase got=%0d bad want=0", phase_bad); end
    checks++; if (!eok) begin errors++; $display("FAIL rst_end_state got=tck%b tms%b want=0,0", jtag_tck, jtag_tms); end
  endtask

  task automatic test_idcode();
    logic [31:0] rsp, er; logic [127:0] es; int ec, p; bit rok, eok, tmo;
    model_step(2, 32, 32'h0, er, es, ec);
    do_cmd(2'd2, 32, 32'h0, 1'b0, rsp, rok, p, eok, tmo);
    checks++; if (rsp !== 32'h0000_09DD) begin errors++; $display("FAIL idcode_rsp got=%h want=000009dd", rsp); end
    checks++; if (mon_ntck !== 37) begin errors++; $display("FAIL idcode_tck_count got=%0d want=37", mon_ntck); end
    checks++; if (mon_seq !== es || !rok || p != 1 || !eok) begin errors++; $display("FAIL idcode_proto seq_ok=%b ready_ok=%b pulses=%0d end_ok=%b", mon_seq === es, rok, p, eok); end
  endtask

  task automatic test_ir_bypass();
    logic [31:0] rsp, er; logic [127:0] es; int ec, p; bit rok, eok, tmo;
    model_step(1, 4, 32'hF, er, es, ec);
    do_cmd(2'd1, 4, 32'hF, 1'b0, rsp, rok, p, eok, tmo);
    checks++; if (rsp !== 32'h1) begin errors++; $display("FAIL ir_rsp got=%h want=1", rsp); end
    checks++; if (mon_ntck !== 10 || mon_seq !== es) begin errors++; $display("FAIL ir_walk got=%0d tck want=10", mon_ntck); end
    model_step(2, 3, 32'h5, er, es, ec);
    do_cmd(2'd2, 3, 32'hFFFF_FFFD, 1'b0, rsp, rok, p, eok, tmo);
    checks++; if (rsp !== 32'h2) begin errors++; $display("FAIL bypass_rsp got=%h want=2", rsp); end
    checks++; if (mon_ntck !== 8 || mon_seq !== es) begin errors++; $display("FAIL bypass_walk got=%0d tck want=8", mon_ntck); end
  endtask

  task automatic test_first_idle();
    logic [31:0] rsp, er; logic [127:0] es; int ec, p; bit rok, eok, tmo;
    @(posedge clk); #1; tap_resetn = 1'b0; m_synced = 1'b0;
    @(posedge clk); #1; tap_resetn = 1'b1;
    model_step(3, 3, 32'h0, er, es, ec);
    do_cmd(2'd3, 3, 32'hFFFF_FFFF, 1'b0, rsp, rok, p, eok, tmo);
    checks++; if (mon_ntck !== 9) begin errors++; $display("FAIL idle_tck_count got=%0d want=9", mon_ntck); end
    checks++; if (mon_seq[8:0] !== 9'b000011111) begin errors++; $display("FAIL idle_tms_seq got=%b want=000011111", mon_seq[8:0]); end
    checks++; if (rsp !== 32'h0) begin errors++; $display("FAIL idle_rsp got=%h want=0", rsp); end
    checks++; if (!rok || p != 1 || !eok || phase_bad != 0) begin errors++; $display("FAIL idle_proto ready_ok=%b pulses=%0d end_ok=%b phase_bad=%0d", rok, p, eok, phase_bad); end
  endtask

  task automatic test_abort();
    logic [31:0] rsp, er; logic [127:0] es; int ec, p, seen; bit rok, eok, tmo;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_len = LEN_W'(32); bus.cmd_data = $urandom;
    @(posedge clk); #1; bus.cmd_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1; mon_en = 1'b0; tap_resetn = 1'b0;
    #1;
    checks++; if (jtag_tck !== 1'b0 || jtag_tms !== 1'b1) begin errors++; $display("FAIL abort_pins got=tck%b tms%b want=tck0 tms1", jtag_tck, jtag_tms); end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_ready got=ready%b busy%b want=1,0", bus.cmd_ready, bus.busy); end
    checks++; if (bus.rsp_data !== '0) begin errors++; $display("FAIL abort_rsp_data got=%h want=0", bus.rsp_data); end
    m_synced = 1'b0;
    @(posedge clk); #1; tap_resetn = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.rsp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp got=%0d pulses want=0", seen); end
    model_step(2, 8, 32'hA5, er, es, ec);
    do_cmd(2'd2, 8, 32'hA5, 1'b0, rsp, rok, p, eok, tmo);
    checks++; if (mon_ntck !== 19 || mon_seq !== es) begin errors++; $display("FAIL abort_resync_walk got=%0d tck want=19", mon_ntck); end
    checks++; if (rsp !== 32'hDD) begin errors++; $display("FAIL abort_resync_rsp got=%h want=dd", rsp); end
  endtask

  task automatic test_len0_busy();
    logic [31:0] rsp, er; logic [127:0] es; int ec, p; bit rok, eok, tmo;
    model_step(1, 4, {28'h0, IR_IDCODE}, er, es, ec);
    do_cmd(2'd1, 4, {28'h0, IR_IDCODE}, 1'b0, rsp, rok, p, eok, tmo);
    checks++; if (rsp !== 32'h1) begin errors++; $display("FAIL load_idcode_rsp got=%h want=1", rsp); end
    model_step(2, 0, 32'h1234_5678, er, es, ec);
    do_cmd(2'd2, 0, 32'h1234_5678, 1'b1, rsp, rok, p, eok, tmo);
    checks++; if (rsp !== 32'h0000_09DD) begin errors++; $display("FAIL len0_rsp got=%h want=000009dd", rsp); end
    checks++; if (mon_ntck !== 37 || mon_seq !== es) begin errors++; $display("FAIL len0_walk got=%0d tck want=37", mon_ntck); end
    checks++; if (!rok || p != 1 || !eok) begin errors++; $display("FAIL busy_ignore ready_ok=%b pulses=%0d end_ok=%b want=1,1,1", rok, p, eok); end
  endtask

  task automatic test_random();
    logic [31:0] rsp, er, d; logic [127:0] es; int ec, p, op, len; bit rok, eok, tmo;
    for (int k = 0; k < 16; k++) begin
      op = $urandom_range(0, 3); len = $urandom_range(0, 40); d = $urandom;
      model_step(op, len, d, er, es, ec);
      do_cmd(2'(op), len, d, 1'b0, rsp, rok, p, eok, tmo);
      checks++; if (rsp !== er) begin errors++; $display("FAIL rand%0d_rsp op=%0d len=%0d got=%h want=%h", k, op, len, rsp, er); end
      checks++; if (mon_ntck !== ec) begin errors++; $display("FAIL rand%0d_tck op=%0d len=%0d got=%0d want=%0d", k, op, len, mon_ntck, ec); end
      checks++; if (mon_seq !== es) begin errors++; $display("FAIL rand%0d_tms got=%h want=%h", k, mon_seq, es); end
      checks++; if (!rok || p != 1 || !eok || phase_bad != 0) begin errors++; $display("FAIL rand%0d_proto ready_ok=%b pulses=%0d end_ok=%b phase_bad=%0d", k, rok, p, eok, phase_bad); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_len = '0; bus.cmd_data = '0;
    test_reset();
    test_reset_cmd();
    test_idcode();
    test_ir_bypass();
    test_first_idle();
    test_abort();
    test_len0_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
